// File: rtl/dec_entry_pkg.sv
// dec_entry_pkg: shared types and limits for the decimal-entry front end
package dec_entry_pkg;
  localparam int MAX_DIGITS = 3;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [9:0] BIN_MAX = 10'd255;
  typedef enum logic [1:0] {IDLE = 2'd0, ENTRY = 2'd1, CONV = 2'd2} state_e;
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ENTRY = ENTRY;
  localparam logic [1:0] S_CONV  = CONV;
endpackage

// File: rtl/dec_entry_if.sv
// dec_entry_if: keypad strobes in, echo and converted result out
interface dec_entry_if;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        bksp;
  logic        clear;
  logic        enter;
  logic        ready;
  logic [1:0]  count;
  logic [11:0] echo_bcd;
  logic [7:0]  write_data;
  logic        write_valid;
  logic        ovf;
  logic        bad_digit;
  modport master (output digit_valid, digit, bksp, clear, enter,
                  input ready, count, echo_bcd, write_data, write_valid, ovf, bad_digit);
  modport slave  (input digit_valid, digit, bksp, clear, enter,
                  output ready, count, echo_bcd, write_data, write_valid, ovf, bad_digit);
endinterface

// File: rtl/dec_entry_mul10_add.sv
// mul10_add: one decimal multiply-accumulate step, acc*10 + digit
module mul10_add (
  input  logic [9:0] acc,
  input  logic [3:0] digit,
  output logic [9:0] res
);
  assign res = (acc << 3) + (acc << 1) + {6'd0, digit};
endmodule

// File: rtl/dec_entry.sv
// dec_entry: collects up to three BCD digits and converts them to an 8-bit value
module dec_entry #(
  parameter int MAX_DIGITS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  dec_entry_if.slave  bus
);
  import dec_entry_pkg::*;
  logic [1:0]  state_q, state_d, count_q, count_d, step_q, step_d;
  logic [11:0] echo_q, echo_d;
  logic [9:0]  acc_q, acc_d, mac;
  logic [7:0]  wdata_q, wdata_d;
  logic        wvalid_q, wvalid_d, ovf_q, ovf_d, bad_q, bad_d;
  logic [3:0]  cur;
  // hundreds, tens, units in step order; leading zeros keep right alignment correct
  assign cur = step_q == 2'd0 ? echo_q[11:8] : step_q == 2'd1 ? echo_q[7:4] : echo_q[3:0];
  mul10_add u_mac (.acc(acc_q), .digit(cur), .res(mac));
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    step_d   = step_q;
    echo_d   = echo_q;
    acc_d    = acc_q;
    wdata_d  = wdata_q;
    wvalid_d = 1'b0;
    ovf_d    = 1'b0;
    bad_d    = 1'b0;
    if (state_q == S_CONV) begin
      acc_d  = mac;
      step_d = step_q + 2'd1;
      if (step_q == 2'd2) begin
        state_d  = S_IDLE;
        count_d  = 2'd0;
        echo_d   = 12'd0;
        step_d   = 2'd0;
        wvalid_d = mac <= BIN_MAX;
        ovf_d    = mac > BIN_MAX;
        wdata_d  = mac <= BIN_MAX ? mac[7:0] : wdata_q;
      end
    end else if (bus.clear) begin
      state_d = S_IDLE;
      count_d = 2'd0;
      echo_d  = 12'd0;
    end else if (bus.enter) begin
      if (count_q != 2'd0) begin
        state_d = S_CONV;
        acc_d   = 10'd0;
        step_d  = 2'd0;
      end
    end else if (bus.bksp) begin
      if (count_q != 2'd0) begin
        echo_d  = {4'd0, echo_q[11:4]};
        count_d = count_q - 2'd1;
        state_d = count_q == 2'd1 ? S_IDLE : S_ENTRY;
      end
    end else if (bus.digit_valid) begin
      if (bus.digit <= BCD_MAX && count_q < 2'(MAX_DIGITS)) begin
        echo_d  = {echo_q[7:0], bus.digit};
        count_d = count_q + 2'd1;
        state_d = S_ENTRY;
      end else begin
        bad_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= 2'd0;
      step_q   <= 2'd0;
      echo_q   <= 12'd0;
      acc_q    <= 10'd0;
      wdata_q  <= 8'd0;
      wvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      step_q   <= step_d;
      echo_q   <= echo_d;
      acc_q    <= acc_d;
      wdata_q  <= wdata_d;
      wvalid_q <= wvalid_d;
      ovf_q    <= ovf_d;
      bad_q    <= bad_d;
    end
  end
  assign bus.ready       = state_q != S_CONV;
  assign bus.count       = count_q;
  assign bus.echo_bcd    = echo_q;
  assign bus.write_data  = wdata_q;
  assign bus.write_valid = wvalid_q;
  assign bus.ovf         = ovf_q;
  assign bus.bad_digit   = bad_q;
endmodule

// File: tb/tb_dec_entry.sv
// tb_dec_entry: directed checks of digit entry, conversion, overflow and reset abort
module tb_dec_entry;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  dec_entry_if bus ();
  dec_entry #(.MAX_DIGITS(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.digit_valid = 1'b0;
    bus.digit = 4'd0;
    bus.bksp = 1'b0;
    bus.clear = 1'b0;
    bus.enter = 1'b0;
  endtask

  task automatic put_digit(input logic [3:0] d);
    bus.digit_valid = 1'b1;
    bus.digit = d;
    cyc();
    idle_in();
  endtask

  task automatic put_enter();
    bus.enter = 1'b1;
    cyc();
    idle_in();
  endtask

  initial begin
    idle_in();
    cyc();
    cyc();
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_echo", 32'(bus.echo_bcd), 32'd0);
    chk("rst_wdata", 32'(bus.write_data), 32'd0);
    chk("rst_pulses", 32'({bus.write_valid, bus.ovf, bus.bad_digit}), 32'd0);
    rst_n = 1'b1;
    cyc();
    // 1,2,8 -> 128
    put_digit(4'd1);
    put_digit(4'd2);
    put_digit(4'd8);
    chk("e128_count", 32'(bus.count), 32'd3);
    chk("e128_echo", 32'(bus.echo_bcd), 32'h128);
    put_enter();
    chk("e128_ready_low", 32'(bus.ready), 32'd0);
    cyc();
    cyc();
    chk("e128_early", 32'(bus.write_valid), 32'd0);
    cyc();
    chk("e128_wvalid", 32'(bus.write_valid), 32'd1);
    chk("e128_wdata", 32'(bus.write_data), 32'd128);
    chk("e128_ready", 32'(bus.ready), 32'd1);
    chk("e128_echo_clr", 32'(bus.echo_bcd), 32'd0);
    chk("e128_count_clr", 32'(bus.count), 32'd0);
    cyc();
    chk("e128_wvalid_off", 32'(bus.write_valid), 32'd0);
    // 2,5,6 -> overflow, write_data keeps 128
    put_digit(4'd2);
    put_digit(4'd5);
    put_digit(4'd6);
    put_enter();
    cyc();
    cyc();
    cyc();
    chk("ovf_pulse", 32'(bus.ovf), 32'd1);
    chk("ovf_no_wvalid", 32'(bus.write_valid), 32'd0);
    chk("ovf_wdata_kept", 32'(bus.write_data), 32'd128);
    chk("ovf_echo_clr", 32'(bus.echo_bcd), 32'd0);
    cyc();
    chk("ovf_off", 32'(bus.ovf), 32'd0);
    // illegal digit and overfull entry
    put_digit(4'hC);
    chk("bad_hex", 32'(bus.bad_digit), 32'd1);
    chk("bad_hex_count", 32'(bus.count), 32'd0);
    chk("bad_hex_echo", 32'(bus.echo_bcd), 32'd0);
    cyc();
    chk("bad_hex_off", 32'(bus.bad_digit), 32'd0);
    put_digit(4'd3);
    put_digit(4'd4);
    put_digit(4'd5);
    put_digit(4'd6);
    chk("bad_full", 32'(bus.bad_digit), 32'd1);
    chk("bad_full_count", 32'(bus.count), 32'd3);
    chk("bad_full_echo", 32'(bus.echo_bcd), 32'h345);
    bus.clear = 1'b1;
    cyc();
    idle_in();
    chk("clear_count", 32'(bus.count), 32'd0);
    chk("clear_echo", 32'(bus.echo_bcd), 32'd0);
    // 7,3,bksp,5 -> 75; enter beats digit_valid
    put_digit(4'd7);
    put_digit(4'd3);
    bus.bksp = 1'b1;
    cyc();
    idle_in();
    chk("bksp_count", 32'(bus.count), 32'd1);
    chk("bksp_echo", 32'(bus.echo_bcd), 32'h007);
    put_digit(4'd5);
    chk("e75_echo", 32'(bus.echo_bcd), 32'h075);
    bus.enter = 1'b1;
    bus.digit_valid = 1'b1;
    bus.digit = 4'd1;
    cyc();
    idle_in();
    chk("prio_ready", 32'(bus.ready), 32'd0);
    chk("prio_echo", 32'(bus.echo_bcd), 32'h075);
    chk("prio_count", 32'(bus.count), 32'd2);
    cyc();
    cyc();
    cyc();
    chk("e75_wvalid", 32'(bus.write_valid), 32'd1);
    chk("e75_wdata", 32'(bus.write_data), 32'd75);
    // digit strobed during the write_valid cycle
    put_digit(4'd1);
    chk("b2b_count", 32'(bus.count), 32'd1);
    chk("b2b_echo", 32'(bus.echo_bcd), 32'h001);
    bus.bksp = 1'b1;
    cyc();
    idle_in();
    bus.bksp = 1'b1;
    cyc();
    idle_in();
    chk("bksp_empty_count", 32'(bus.count), 32'd0);
    chk("bksp_empty_bad", 32'(bus.bad_digit), 32'd0);
    // enter while empty does nothing
    put_enter();
    for (int i = 0; i < 4; i++) begin
      chk("empty_enter_ready", 32'(bus.ready), 32'd1);
      chk("empty_enter_pulses", 32'({bus.write_valid, bus.ovf, bus.bad_digit}), 32'd0);
      cyc();
    end
    // clear during CONV is ignored
    put_digit(4'd4);
    put_digit(4'd2);
    put_enter();
    bus.clear = 1'b1;
    cyc();
    idle_in();
    chk("conv_clear_count", 32'(bus.count), 32'd2);
    chk("conv_clear_echo", 32'(bus.echo_bcd), 32'h042);
    cyc();
    cyc();
    chk("conv_clear_wvalid", 32'(bus.write_valid), 32'd1);
    chk("conv_clear_wdata", 32'(bus.write_data), 32'd42);
    cyc();
    // reset mid-conversion
    put_digit(4'd9);
    put_digit(4'd9);
    put_enter();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(bus.ready), 32'd1);
    chk("abort_count", 32'(bus.count), 32'd0);
    chk("abort_echo", 32'(bus.echo_bcd), 32'd0);
    chk("abort_wdata", 32'(bus.write_data), 32'd0);
    chk("abort_pulses", 32'({bus.write_valid, bus.ovf, bus.bad_digit}), 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("abort_quiet", 32'({bus.write_valid, bus.ovf, bus.ready}), 32'd1);
    end
    put_digit(4'd5);
    put_enter();
    cyc();
    cyc();
    cyc();
    chk("after_abort_wvalid", 32'(bus.write_valid), 32'd1);
    chk("after_abort_wdata", 32'(bus.write_data), 32'd5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
